// File: rtl/multi_channel_shadow_pwm_if.sv
// multi_channel_shadow_pwm_if: CPU register bus for the shadowed PWM block
interface multi_channel_shadow_pwm_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int SELW = $clog2(NUM_CH + 2);
  logic             cpu_wr;
  logic [SELW-1:0]  cpu_sel;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_commit;
  logic             commit_pending;
  modport master (output cpu_wr, cpu_sel, cpu_wdata, cpu_commit, input commit_pending);
  modport slave  (input cpu_wr, cpu_sel, cpu_wdata, cpu_commit, output commit_pending);
endinterface

// File: rtl/multi_channel_shadow_pwm.sv
// multi_channel_shadow_pwm: shared-counter PWM with shadow registers committed atomically at frame boundaries
module multi_channel_shadow_pwm #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     pol_inv,
  multi_channel_shadow_pwm_if.slave bus,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  frame_start
);
  localparam int SELW = $clog2(NUM_CH + 2);
  localparam logic [SELW-1:0] SEL_PER  = SELW'(NUM_CH);
  localparam logic [SELW-1:0] SEL_MODE = SELW'(NUM_CH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] duty_sh_q [NUM_CH];
  logic [WIDTH-1:0] duty_sh_d [NUM_CH];
  logic [WIDTH-1:0] duty_ac_q [NUM_CH];
  logic [WIDTH-1:0] duty_ac_d [NUM_CH];
  logic [WIDTH-1:0] per_sh_q, per_sh_d, per_ac_q, per_ac_d;
  logic             mode_sh_q, mode_sh_d, mode_ac_q, mode_ac_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             pending_q, pending_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d, raw;
  logic             fs_q, fs_d;
  logic             bnd, xfer;

  // Frame boundary detection; a disabled block treats every cycle as a boundary
  always_comb begin
    bnd = !en || per_ac_q == '0 ||
          (mode_ac_q ? (cnt_q == ONE && (down_q || per_ac_q == ONE)) : cnt_q == per_ac_q);
    xfer = bnd && pending_q;
  end

  // Shadow register writes from the CPU bus; out-of-range selects fall through untouched
  always_comb begin
    duty_sh_d = duty_sh_q;
    per_sh_d  = bus.cpu_sel == SEL_PER ? bus.cpu_wdata : per_sh_q;
    mode_sh_d = bus.cpu_sel == SEL_MODE ? bus.cpu_wdata[0] : mode_sh_q;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.cpu_sel == SELW'(i)) duty_sh_d[i] = bus.cpu_wdata;
    if (!bus.cpu_wr) begin
      duty_sh_d = duty_sh_q;
      per_sh_d  = per_sh_q;
      mode_sh_d = mode_sh_q;
    end
  end

  // Atomic shadow-to-active transfer; a commit arriving in the boundary cycle re-arms for the next frame
  always_comb begin
    duty_ac_d = xfer ? duty_sh_q : duty_ac_q;
    per_ac_d  = xfer ? per_sh_q : per_ac_q;
    mode_ac_d = xfer ? mode_sh_q : mode_ac_q;
    pending_d = bus.cpu_commit || (pending_q && !bnd);
  end

  // Shared counter: edge mode wraps at period, center mode turns around at period and again at 1
  always_comb begin
    cnt_d  = cnt_q;
    down_d = down_q;
    if (xfer || !en || per_ac_q == '0) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (!mode_ac_q) cnt_d = cnt_q == per_ac_q ? '0 : cnt_q + ONE;
    else if (!down_q && cnt_q != per_ac_q) cnt_d = cnt_q + ONE;
    else begin
      cnt_d  = cnt_q - ONE;
      down_d = cnt_q > ONE;
    end
  end

  // Per-channel compare with live polarity; idle level is the polarity itself
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = cnt_q < duty_ac_q[i];
    pwm_d = en ? (raw ^ pol_inv) : pol_inv;
    fs_d  = en && cnt_q == '0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '{default: '0};
      duty_ac_q <= '{default: '0};
      per_sh_q  <= '0;
      per_ac_q  <= '0;
      mode_sh_q <= 1'b0;
      mode_ac_q <= 1'b0;
      cnt_q     <= '0;
      down_q    <= 1'b0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      duty_ac_q <= duty_ac_d;
      per_sh_q  <= per_sh_d;
      per_ac_q  <= per_ac_d;
      mode_sh_q <= mode_sh_d;
      mode_ac_q <= mode_ac_d;
      cnt_q     <= cnt_d;
      down_q    <= down_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      fs_q      <= fs_d;
    end
  end

  assign pwm_out            = pwm_q;
  assign frame_start        = fs_q;
  assign bus.commit_pending = pending_q;
endmodule

// File: tb/tb_multi_channel_shadow_pwm.sv
// tb_multi_channel_shadow_pwm: directed checks of the shadowed multi-channel PWM
module tb_multi_channel_shadow_pwm;
  logic clk = 1'b0;
  logic rst, en;
  logic [3:0] pol_inv, pwm_out;
  logic frame_start;
  int n_checks = 0;
  int n_errors = 0;
  multi_channel_shadow_pwm_if #(.NUM_CH(4), .WIDTH(8)) bus ();
  multi_channel_shadow_pwm #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .pol_inv(pol_inv), .bus(bus),
    .pwm_out(pwm_out), .frame_start(frame_start)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    bus.cpu_wr = 1'b1;
    bus.cpu_sel = sel;
    bus.cpu_wdata = d;
    tick();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic commit;
    bus.cpu_commit = 1'b1;
    tick();
    bus.cpu_commit = 1'b0;
  endtask

  task automatic wait_fs;
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 40);
    chk("sync_fs", int'(frame_start), 1);
  endtask

  task automatic wait_xfer(input string tag);
    int n = 0;
    while (bus.commit_pending && n < 40) begin
      tick();
      n++;
    end
    chk(tag, int'(bus.commit_pending), 0);
  endtask

  initial begin
    int h0, h1, f;
    logic [7:0] pat, fpat;
    rst = 1'b1; en = 1'b0; pol_inv = '0;
    bus.cpu_wr = 1'b0; bus.cpu_sel = '0; bus.cpu_wdata = '0; bus.cpu_commit = 1'b0;
    tick(); tick();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_pend", int'(bus.commit_pending), 0);
    rst = 1'b0;

    // edge mode duty 3 / period 7, committed while disabled
    wr(0, 3); wr(4, 7); commit();
    chk("t1_pend_set", int'(bus.commit_pending), 1);
    tick();
    chk("t1_pend_clr", int'(bus.commit_pending), 0);
    en = 1'b1;
    h0 = 0; f = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      h0 += int'(pwm_out[0]);
      f += int'(frame_start);
    end
    chk("t1_high", h0, 6);
    chk("t1_fs", f, 2);

    // mid-frame update to duty 5 waits for the boundary
    wait_fs();
    wr(0, 5); commit();
    chk("t2_pend", int'(bus.commit_pending), 1);
    tick();
    chk("t2_old_duty", int'(pwm_out[0]), 0);
    tick(); tick(); tick();
    chk("t2_pend_hold", int'(bus.commit_pending), 1);
    tick();
    chk("t2_pend_fall", int'(bus.commit_pending), 0);
    tick();
    chk("t2_fs", int'(frame_start), 1);
    h0 = int'(pwm_out[0]);
    for (int i = 0; i < 7; i++) begin
      tick();
      h0 += int'(pwm_out[0]);
    end
    chk("t2_high", h0, 5);

    // center mode, period 4, duty1 2
    wr(1, 2); wr(4, 4); wr(5, 1); commit();
    wait_xfer("t3_xfer");
    for (int k = 0; k < 8; k++) begin
      tick();
      pat[k] = pwm_out[1];
      fpat[k] = frame_start;
    end
    chk("t3_pattern", int'(pat), 8'b1000_0011);
    chk("t3_fs_pattern", int'(fpat), 8'b0000_0001);

    // duty extremes and live polarity
    wr(0, 0); wr(1, 8); wr(5, 0); wr(4, 7); commit();
    wait_xfer("t4_xfer");
    tick();
    h0 = 0; h1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
    end
    chk("t4_duty0", h0, 0);
    chk("t4_duty_full", h1, 10);
    chk("t4_pwm", int'(pwm_out), 4'b0010);
    pol_inv = 4'b0011;
    tick();
    chk("t4_pol", int'(pwm_out), 4'b0001);
    pol_inv = '0;
    tick();

    // commit and write landing in the boundary cycle
    wait_fs();
    wr(0, 4);
    for (int i = 0; i < 5; i++) tick();
    commit();
    chk("t5_pend_defer", int'(bus.commit_pending), 1);
    tick();
    chk("t5_pend_hold", int'(bus.commit_pending), 1);
    chk("t5_not_applied", int'(pwm_out[0]), 0);
    for (int i = 0; i < 6; i++) tick();
    wr(0, 6);
    chk("t5_pend_fall", int'(bus.commit_pending), 0);
    h0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      h0 += int'(pwm_out[0]);
    end
    chk("t5_pre_edge_shadow", h0, 4);

    // mid-frame reset with a commit armed, then disable
    commit();
    chk("t6_pend", int'(bus.commit_pending), 1);
    pol_inv = 4'b1111;
    rst = 1'b1;
    tick();
    chk("t6_rst_pwm", int'(pwm_out), 0);
    chk("t6_rst_fs", int'(frame_start), 0);
    chk("t6_rst_pend", int'(bus.commit_pending), 0);
    rst = 1'b0;
    pol_inv = '0;
    h0 = 0; f = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      h0 += int'(pwm_out);
      f += int'(frame_start);
    end
    chk("t6_zero_duty", h0, 0);
    chk("t6_period0_fs", f, 8);
    en = 1'b0;
    pol_inv = 4'b1010;
    tick();
    chk("t6_idle_pwm", int'(pwm_out), 4'b1010);
    chk("t6_idle_fs", int'(frame_start), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
